// File: rtl/fighter_pkg.sv
// fighter_pkg: state encodings shared with the sprite renderer, plus a pixel clamp helper
package fighter_pkg;
  typedef enum logic [2:0] {
    ST_NORMAL = 3'b000,
    ST_PUNCH  = 3'b001,
    ST_HURT   = 3'b010
  } char_state_t;
  typedef enum logic [1:0] {
    MV_IDLE = 2'b00,
    MV_FWD  = 2'b01,
    MV_BACK = 2'b10
  } move_state_t;
  localparam int PHASE_W = 6;
  function automatic logic [6:0] clamp_px(input logic signed [7:0] v, input logic signed [7:0] lo,
                                          input logic signed [7:0] hi);
    return (v < lo) ? lo[6:0] : (v > hi) ? hi[6:0] : v[6:0];
  endfunction
endpackage

// File: rtl/fighter_controller_if.sv
// fighter_controller_if: player controls in (enable, buttons, hit, mirror), sprite state and strike out
interface fighter_controller_if;
  import fighter_pkg::*;
  logic        enable;
  logic        btn_left;
  logic        btn_right;
  logic        btn_up;
  logic        btn_attack;
  logic        hit;
  logic        mirror;
  logic [6:0]  x;
  logic [6:0]  y;
  logic        in_air;
  move_state_t move_state;
  char_state_t character_state;
  logic        strike;
  modport master (
    output enable, btn_left, btn_right, btn_up, btn_attack, hit, mirror,
    input  x, y, in_air, move_state, character_state, strike
  );
  modport slave (
    input  enable, btn_left, btn_right, btn_up, btn_attack, hit, mirror,
    output x, y, in_air, move_state, character_state, strike
  );
endinterface

// File: rtl/fighter_controller_tick_gen.sv
// tick_gen: one-cycle tick every TICK_DIV enabled clocks; ports clk, rst, enable in, tick out
module tick_gen #(
  parameter int TICK_DIV = 1_666_667
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end
  assign tick = enable & ~rst & (cnt == LAST);
endmodule

// File: rtl/fighter_controller.sv
// fighter_controller: frame-tick motion/action sequencer; clk, rst, bus (slave) carries buttons in, sprite state out; optional KNOCKBACK_EN
module fighter_controller
  import fighter_pkg::*;
#(
  parameter int TICK_DIV    = 1_666_667,
  parameter int X_MIN       = 8,
  parameter int X_MAX       = 88,
  parameter int X_INIT      = 24,
  parameter int Y_GROUND    = 40,
  parameter int WALK_STEP   = 1,
  parameter int JUMP_V      = 6,
  parameter int GRAVITY     = 1,
  parameter int PUNCH_TICKS = 45,
  parameter int STRIKE_TICK = 20,
  parameter int HURT_TICKS  = 45
) (
  input logic clk,
  input logic rst,
  fighter_controller_if.slave bus
);
  localparam logic signed [7:0] XMIN = 8'(X_MIN);
  localparam logic signed [7:0] XMAX = 8'(X_MAX);
  localparam logic signed [7:0] YGND = 8'(Y_GROUND);
  localparam logic signed [7:0] STEP = 8'(WALK_STEP);
  localparam logic signed [5:0] JV = 6'(JUMP_V);
  localparam logic signed [5:0] GR = 6'(GRAVITY);
  localparam logic [PHASE_W-1:0] PUNCH_LAST = PHASE_W'(PUNCH_TICKS - 1);
  localparam logic [PHASE_W-1:0] HURT_LAST = PHASE_W'(HURT_TICKS - 1);
  localparam logic [PHASE_W-1:0] STRIKE_PH = PHASE_W'(STRIKE_TICK);
  logic tick, atk_q, atk_pend, hit_pend, atk_now, hit_now;
  char_state_t state, state_n;
  logic [PHASE_W-1:0] phase, phase_n;
  logic [6:0] x, y;
  logic signed [5:0] vy, vy_e;
  logic in_air, walk, knock, start, air, land;
  move_state_t move_state, move_n;
  logic signed [7:0] dx, x_sum, y_sum;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .enable(bus.enable), .tick(tick));
  // events landing on the tick cycle itself are consumed by that tick, so none are lost
  assign atk_now = atk_pend | (bus.btn_attack & ~atk_q);
  assign hit_now = hit_pend | bus.hit;
  always_ff @(posedge clk) begin
    atk_q    <= rst ? 1'b0 : bus.btn_attack;
    atk_pend <= (rst | tick) ? 1'b0 : atk_now;
    hit_pend <= (rst | tick) ? 1'b0 : hit_now;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_NORMAL;
      phase <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end
  always_comb begin
    state_n = state;
    phase_n = phase;
    if (tick) begin
      case (state)
        ST_NORMAL: begin
          state_n = hit_now ? ST_HURT : atk_now ? ST_PUNCH : ST_NORMAL;
          phase_n = '0;
        end
        ST_PUNCH: begin
          phase_n = hit_now ? '0 : phase + 1'b1;
          state_n = hit_now ? ST_HURT : (phase == PUNCH_LAST) ? ST_NORMAL : ST_PUNCH;
        end
        ST_HURT: begin
          phase_n = phase + 1'b1;
          state_n = (phase == HURT_LAST) ? ST_NORMAL : ST_HURT;
        end
        default: state_n = ST_NORMAL;
      endcase
    end
  end
  assign walk = (state == ST_NORMAL) & (bus.btn_left ^ bus.btn_right);
`ifdef KNOCKBACK_EN
  assign knock = (state == ST_HURT) & (phase < PHASE_W'(4));
`else
  assign knock = 1'b0;
`endif
  // knockback pushes away from the facing direction
  assign dx = walk ? (bus.btn_right ? STEP : -STEP) : knock ? (bus.mirror ? 8'sd2 : -8'sd2) : 8'sd0;
  assign x_sum = $signed({1'b0, x}) + dx;
  assign move_n = walk ? ((bus.btn_left == bus.mirror) ? MV_FWD : MV_BACK) : MV_IDLE;
  // the launch tick already applies the first upward step
  assign start = bus.btn_up & ~in_air & (state == ST_NORMAL);
  assign vy_e = start ? -JV : vy;
  assign air = in_air | start;
  assign y_sum = $signed({1'b0, y}) + $signed({{2{vy_e[5]}}, vy_e});
  assign land = y_sum >= YGND;
  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= 7'(X_INIT);
      y          <= 7'(Y_GROUND);
      vy         <= '0;
      in_air     <= 1'b0;
      move_state <= MV_IDLE;
    end else if (tick) begin
      x          <= clamp_px(x_sum, XMIN, XMAX);
      move_state <= move_n;
      if (air) begin
        y      <= land ? 7'(Y_GROUND) : y_sum[6:0];
        vy     <= land ? 6'sd0 : vy_e + GR;
        in_air <= ~land;
      end
    end
  end
  assign bus.x = x;
  assign bus.y = y;
  assign bus.in_air = in_air;
  assign bus.move_state = move_state;
  assign bus.character_state = state;
  assign bus.strike = tick & (state == ST_PUNCH) & (phase == STRIKE_PH) & ~hit_now;
endmodule

// File: doc/fighter_controller.md
Name: fighter_controller

Overview:
- Per-player motion and action sequencer.
- Converts debounced buttons and a collision hit strobe into the x, y, in_air, move_state and character_state signals consumed by the sprite renderer.
- Produces a strike strobe for the hit-detection logic.
- All game-state updates advance on an internal frame tick; inputs arriving between ticks are latched until the next tick.

Parameters:
TICK_DIV, 1_666_667, clk cycles per frame tick (60 Hz at 100 MHz)
X_MIN, 8, leftmost legal x
X_MAX, 88, rightmost legal x
X_INIT, 24, x after reset
Y_GROUND, 40, ground y (screen y grows downward)
WALK_STEP, 1, px moved per tick while walking
JUMP_V, 6, initial upward speed, px/tick
GRAVITY, 1, speed increment per tick
PUNCH_TICKS, 45, punch duration in ticks
STRIKE_TICK, 20, punch tick index at which the strike strobe fires
HURT_TICKS, 45, hit-stun duration in ticks

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  0 = freeze all updates; pending latches hold
btn_left  in  1  level, debounced
btn_right  in  1  level, debounced
btn_up  in  1  level, jump request
btn_attack  in  1  level; a rising edge requests a punch
hit  in  1  1-cycle pulse from collision logic
mirror  in  1  facing: 0 = facing right, 1 = facing left
x  out  7  sprite centre x
y  out  7  sprite centre y
in_air  out  1  airborne flag
move_state  out  2  00 idle, 01 forward, 10 backward
character_state  out  3  000 normal, 001 punch, 010 hurt
strike  out  1  1-cycle pulse, punch active frame

Behaviour:
- Reset (clk edge with rst=1): x=X_INIT, y=Y_GROUND, vy=0, in_air=0, move_state=00, character_state=000, strike=0. Tick counter, phase counter and pending latches cleared. Reset mid-jump or mid-punch aborts immediately.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 for one cycle at TICK_DIV-1. Counter halts while enable=0.
- Latches (set any cycle):
  - atk_pend sets on btn_attack rising edge (one-cycle registered compare).
  - hit_pend sets on hit=1.
  - Both clear on the tick that consumes them.
- State machine, evaluated on tick only:
  - NORMAL: if hit_pend -> HURT, phase=0. Else if atk_pend -> PUNCH, phase=0.
  - PUNCH: phase++. If phase reaches PUNCH_TICKS-1 -> NORMAL. If hit_pend -> HURT (hit wins over punch completion).
  - HURT: phase++. If phase reaches HURT_TICKS-1 -> NORMAL. hit_pend is consumed and ignored (no re-stun).
  - Simultaneous hit_pend and atk_pend in NORMAL: HURT wins; atk_pend is dropped.
  - atk_pend arriving in PUNCH or HURT is discarded; no queuing.
- strike: high for the one clk cycle of the tick on which PUNCH phase == STRIKE_TICK. It is never asserted if the punch is interrupted before that tick.
- Horizontal motion, NORMAL only:
  - Exactly one of btn_left/btn_right pressed: x moves WALK_STEP that way, clamped to [X_MIN, X_MAX].
  - Both or neither pressed: no move, move_state=00.
  - move_state=01 when the direction equals facing (right with mirror=0, left with mirror=1); otherwise 10.
  - At a clamp boundary, x holds but move_state still reflects the pressed direction.
  - In PUNCH or HURT, move_state=00 and there is no horizontal motion.
- Vertical motion:
  - Jump starts when btn_up=1, in_air=0 and state is NORMAL: in_air=1, vy=-JUMP_V.
  - Each airborne tick, in all states: y += vy, then vy += GRAVITY (vy is signed 6-bit).
  - If the new y >= Y_GROUND: y=Y_GROUND, vy=0, in_air=0.
  - A punch is allowed while airborne; the jump continues during PUNCH and HURT.
- Arithmetic: x and y are computed in 8-bit signed before clamping, so no wrap-around is possible.

Optional Feature:
- Macro KNOCKBACK_EN.
- Defined: during the first 4 ticks of HURT, x moves 2 px away from facing (opposite of forward), clamped to [X_MIN, X_MAX].
- Undefined: x is frozen during HURT.

Decomposition:
- Package fighter_pkg holds the character_state encodings (ST_NORMAL=3'b000, ST_PUNCH=3'b001, ST_HURT=3'b010) and the move_state encodings (MV_IDLE, MV_FWD, MV_BACK). The sprite renderer shares these.
- One sub-module, tick_gen (parameter TICK_DIV; inputs clk, rst, enable; output tick). It is reusable by other frame-rate logic.

Test Plan (bench TICK_DIV=4, other parameters at default):
- Reset release, idle 10 ticks -> x=24, y=40, in_air=0, move_state=00, character_state=000, strike never high.
- mirror=0, btn_right held 70 ticks -> x increments 1 per tick and saturates at 88; move_state=01 throughout. Repeat with mirror=1 -> move_state=10.
- btn_up pulsed while grounded -> y sequence 34,29,25,22,20,19,19,20,22,25,29,34,40; in_air falls on the 13th tick; vy=0 afterwards.
- btn_attack rising edge -> character_state=001 for 45 ticks then 000; exactly one strike pulse, on phase-20 tick; held btn_attack does not retrigger.
- hit at punch phase 10 -> character_state=010 next tick with no strike pulse; second hit during HURT -> no extension; returns to 000 after 45 ticks. With KNOCKBACK_EN, mirror=0, x=24 -> x=16 after 4 ticks.
- hit and attack edge in the same tick window from NORMAL -> HURT. rst asserted mid-jump -> next cycle y=40, in_air=0.
